// File: rtl/accel_filter_sampler.sv
// Accelerometer output stage: per-channel moving average over 2^LOG_DEPTH sample sets,
// republished as saturated OUT_W-bit values on a programmable refresh tick.
module accel_filter_sampler #(
    parameter int NUM_CH      = 3,
    parameter int IN_W        = 16,
    parameter int OUT_W       = 10,
    parameter int LOG_DEPTH   = 2,
    parameter int REFRESH_DIV = 5000000
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_CH*IN_W-1:0]    data_in,
    input  logic                      data_update,
    input  logic                      freeze,
    output logic [NUM_CH*OUT_W-1:0]   data_out,
    output logic                      out_valid,
    output logic                      busy,
    output logic                      filled,
    output logic                      overrun
);

    localparam int DEPTH  = 1 << LOG_DEPTH;
    localparam int SUM_W  = IN_W + LOG_DEPTH;
    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int CNT_W  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int FILL_W = LOG_DEPTH + 1;

    localparam logic signed [IN_W-1:0] SAT_MAX = {{(IN_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [IN_W-1:0] SAT_MIN = {{(IN_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, ACCUM, COMMIT} state_t;

    state_t                   state_q, state_d;
    logic [CH_W-1:0]          ch_idx_q, ch_idx_d;
    logic [LOG_DEPTH-1:0]     wptr_q;
    logic [FILL_W-1:0]        fill_q;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic                     overrun_q, overrun_d;
    logic                     out_valid_q, out_valid_d;
    logic [NUM_CH*OUT_W-1:0]  data_out_q, data_out_d;
    logic [NUM_CH*OUT_W-1:0]  sat_pack;

    logic signed [IN_W-1:0]   stage_q [NUM_CH];
    logic signed [IN_W-1:0]   ring_q  [NUM_CH][DEPTH];
    logic signed [SUM_W-1:0]  sum_q   [NUM_CH];
    logic signed [IN_W-1:0]   avg_q   [NUM_CH];

    logic                     accept, tick, filled_w, load_out;
    logic signed [IN_W-1:0]   cur_new, cur_old;
    logic signed [SUM_W-1:0]  sum_nxt;

    function automatic logic [OUT_W-1:0] saturate(input logic signed [IN_W-1:0] a);
        logic [OUT_W-1:0] r;
        if (a > SAT_MAX)
            r = SAT_MAX[OUT_W-1:0];
        else if (a < SAT_MIN)
            r = SAT_MIN[OUT_W-1:0];
        else
            r = a[OUT_W-1:0];
        return r;
    endfunction

    // FSM: state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            ch_idx_q <= '0;
        end else begin
            state_q  <= state_d;
            ch_idx_q <= ch_idx_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d  = state_q;
        ch_idx_d = ch_idx_q;
        case (state_q)
            IDLE: begin
                if (data_update) begin
                    state_d  = ACCUM;
                    ch_idx_d = '0;
                end
            end
            ACCUM: begin
                if (ch_idx_q == CH_W'(NUM_CH - 1))
                    state_d = COMMIT;
                else
                    ch_idx_d = ch_idx_q + 1'b1;
            end
            COMMIT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        busy = (state_q != IDLE);
    end

    assign accept   = (state_q == IDLE) && data_update;
    assign tick     = (cnt_q == CNT_W'(REFRESH_DIV - 1));
    assign filled_w = (fill_q == FILL_W'(DEPTH));
    assign load_out = tick && filled_w && !freeze;

    // Running sum swaps the oldest ring entry for the new sample, one channel per cycle.
    always_comb begin
        cur_new = stage_q[ch_idx_q];
        cur_old = ring_q[ch_idx_q][wptr_q];
        sum_nxt = sum_q[ch_idx_q] + SUM_W'(cur_new) - SUM_W'(cur_old);
    end

    always_comb begin
        sat_pack = '0;
        for (int c = 0; c < NUM_CH; c++)
            sat_pack[c*OUT_W +: OUT_W] = saturate(avg_q[c]);
    end

    always_comb begin
        cnt_d       = tick ? '0 : cnt_q + 1'b1;
        overrun_d   = overrun_q | (data_update && busy);
        out_valid_d = load_out;
        data_out_d  = load_out ? sat_pack : data_out_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int c = 0; c < NUM_CH; c++) begin
                stage_q[c] <= '0;
                sum_q[c]   <= '0;
                avg_q[c]   <= '0;
                for (int d = 0; d < DEPTH; d++)
                    ring_q[c][d] <= '0;
            end
            wptr_q <= '0;
            fill_q <= '0;
        end else begin
            if (accept) begin
                for (int c = 0; c < NUM_CH; c++)
                    stage_q[c] <= data_in[c*IN_W +: IN_W];
            end
            if (state_q == ACCUM) begin
                sum_q[ch_idx_q]          <= sum_nxt;
                ring_q[ch_idx_q][wptr_q] <= cur_new;
            end
            if (state_q == COMMIT) begin
                // Dropping the low LOG_DEPTH bits of a signed sum is floor division.
                for (int c = 0; c < NUM_CH; c++)
                    avg_q[c] <= sum_q[c][SUM_W-1:LOG_DEPTH];
                wptr_q <= wptr_q + 1'b1;
                if (!filled_w)
                    fill_q <= fill_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q       <= '0;
            overrun_q   <= 1'b0;
            out_valid_q <= 1'b0;
            data_out_q  <= '0;
        end else begin
            cnt_q       <= cnt_d;
            overrun_q   <= overrun_d;
            out_valid_q <= out_valid_d;
            data_out_q  <= data_out_d;
        end
    end

    assign data_out  = data_out_q;
    assign out_valid = out_valid_q;
    assign filled    = filled_w;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_accel_filter_sampler.sv
// Directed bench for accel_filter_sampler: a moving-average model feeds a scoreboard
// queue that is drained on each observed out_valid pulse.
module tb_accel_filter_sampler;

    localparam int NUM_CH = 3, IN_W = 16, OUT_W = 10, LOG_DEPTH = 2, REFRESH_DIV = 8;

    logic                    clk = 1'b0;
    logic                    rst = 1'b0;
    logic [NUM_CH*IN_W-1:0]  data_in = '0;
    logic                    data_update = 1'b0;
    logic                    freeze = 1'b0;
    logic [NUM_CH*OUT_W-1:0] data_out;
    logic                    out_valid, busy, filled, overrun;

    int tests = 0;
    int fails = 0;
    int pulses = 0;
    int snap;
    logic [29:0] sb[$];
    logic [29:0] last_out = '0;
    int ring_m[3][4];
    int wptr_m = 0;
    int fill_m = 0;

    accel_filter_sampler #(
        .NUM_CH(NUM_CH), .IN_W(IN_W), .OUT_W(OUT_W),
        .LOG_DEPTH(LOG_DEPTH), .REFRESH_DIV(REFRESH_DIV)
    ) dut (
        .clk(clk), .rst(rst), .data_in(data_in), .data_update(data_update),
        .freeze(freeze), .data_out(data_out), .out_valid(out_valid),
        .busy(busy), .filled(filled), .overrun(overrun)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (out_valid === 1'b1) pulses++;

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < 3; c++)
            for (int d = 0; d < 4; d++)
                ring_m[c][d] = 0;
        wptr_m = 0;
        fill_m = 0;
    endtask

    function automatic logic [29:0] model_out();
        logic [29:0] r;
        int s, a;
        r = '0;
        for (int c = 0; c < 3; c++) begin
            s = 0;
            for (int d = 0; d < 4; d++) s += ring_m[c][d];
            a = s >>> 2;
            if (a > 511) a = 511;
            if (a < -512) a = -512;
            r[c*10 +: 10] = 10'(a);
        end
        return r;
    endfunction

    task automatic model_apply(int x, int y, int z);
        ring_m[0][wptr_m] = x;
        ring_m[1][wptr_m] = y;
        ring_m[2][wptr_m] = z;
        wptr_m = (wptr_m + 1) % 4;
        if (fill_m < 4) fill_m++;
    endtask

    task automatic send_set(int x, int y, int z);
        @(negedge clk);
        data_in = {16'(z), 16'(y), 16'(x)};
        data_update = 1'b1;
        @(negedge clk);
        data_update = 1'b0;
        model_apply(x, y, z);
        repeat (10) @(negedge clk);
    endtask

    task automatic expect_tick(string tag);
        logic [29:0] exp;
        int n;
        exp = sb.pop_front();
        n = 0;
        while (out_valid !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_tick"}, {31'd0, out_valid}, 32'd1);
        check(tag, {2'b0, data_out}, {2'b0, exp});
        last_out = exp;
        @(negedge clk);
        check({tag, "_pulse"}, {31'd0, out_valid}, 32'd0);
    endtask

    initial begin
        model_reset();
        repeat (3) @(negedge clk);
        rst = 1'b1;
        snap = pulses;
        repeat (20) @(negedge clk);
        check("rst_data",    {2'b0, data_out}, 32'd0);
        check("rst_pulses",  pulses - snap, 32'd0);
        check("rst_filled",  {31'd0, filled}, 32'd0);
        check("rst_busy",    {31'd0, busy}, 32'd0);
        check("rst_overrun", {31'd0, overrun}, 32'd0);

        // Constant sets fill the window
        for (int i = 0; i < 3; i++) send_set(100, -50, 256);
        check("fill_3", {31'd0, filled}, 32'd0);
        send_set(100, -50, 256);
        check("fill_4", {31'd0, filled}, 32'd1);
        sb.push_back(model_out());
        expect_tick("const");
        check("const_lit", {2'b0, data_out}, {2'b0, 10'h100, 10'h3CE, 10'h064});

        // Ramp and slide
        send_set(0, 0, 0); send_set(4, 0, 0); send_set(8, 0, 0); send_set(12, 0, 0);
        sb.push_back(model_out());
        expect_tick("ramp");
        check("ramp_x", {22'd0, data_out[9:0]}, 32'h006);
        send_set(16, 0, 0);
        sb.push_back(model_out());
        expect_tick("slide");
        check("slide_x", {22'd0, data_out[9:0]}, 32'h00A);

        // Floor rounding of a negative sum
        send_set(-1, 0, 0); send_set(0, 0, 0); send_set(0, 0, 0); send_set(0, 0, 0);
        sb.push_back(model_out());
        expect_tick("floor");
        check("floor_x", {22'd0, data_out[9:0]}, 32'h3FF);

        // Saturation at both rails
        for (int i = 0; i < 4; i++) send_set(32767, 0, 0);
        sb.push_back(model_out());
        expect_tick("sat_hi");
        check("sat_hi_x", {22'd0, data_out[9:0]}, 32'h1FF);
        for (int i = 0; i < 4; i++) send_set(-32768, 0, 0);
        sb.push_back(model_out());
        expect_tick("sat_lo");
        check("sat_lo_x", {22'd0, data_out[9:0]}, 32'h200);

        // Freeze holds the output while the averages move
        freeze = 1'b1;
        snap = pulses;
        for (int i = 0; i < 4; i++) send_set(20, 30, -40);
        repeat (16) @(negedge clk);
        check("frz_pulses", pulses - snap, 32'd0);
        check("frz_hold",   {2'b0, data_out}, {2'b0, last_out});
        freeze = 1'b0;
        sb.push_back(model_out());
        expect_tick("unfreeze");

        // Back-to-back strobes: second set dropped, overrun sticks
        check("ovr_pre", {31'd0, overrun}, 32'd0);
        @(negedge clk);
        data_in = {16'(42), 16'(41), 16'(40)};
        data_update = 1'b1;
        @(negedge clk);
        data_in = {16'(-300), 16'(-300), 16'(-300)};
        @(negedge clk);
        data_update = 1'b0;
        model_apply(40, 41, 42);
        repeat (10) @(negedge clk);
        check("ovr_set", {31'd0, overrun}, 32'd1);
        sb.push_back(model_out());
        expect_tick("ovr_avg");
        repeat (10) @(negedge clk);
        check("ovr_sticky", {31'd0, overrun}, 32'd1);

        // Reset in the middle of accumulation
        @(negedge clk);
        data_in = {16'(7), 16'(7), 16'(7)};
        data_update = 1'b1;
        @(negedge clk);
        data_update = 1'b0;
        check("mid_busy", {31'd0, busy}, 32'd1);
        rst = 1'b0;
        #1;
        model_reset();
        check("mid_data",    {2'b0, data_out}, 32'd0);
        check("mid_valid",   {31'd0, out_valid}, 32'd0);
        check("mid_busy0",   {31'd0, busy}, 32'd0);
        check("mid_filled",  {31'd0, filled}, 32'd0);
        check("mid_overrun", {31'd0, overrun}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        snap = pulses;
        repeat (20) @(negedge clk);
        check("post_pulses", pulses - snap, 32'd0);
        check("post_data",   {2'b0, data_out}, 32'd0);
        check("post_busy",   {31'd0, busy}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
